mesh_term_tx: RTL

MESH_TERM_TX -- requirements
Module: mesh_term_tx

---
 rtl/mesh_term_tx_pkg.sv | 56 +++++
 rtl/mesh_term_fifo.sv | 56 +++++
 rtl/mesh_term_tx.sv | 76 +++++++
 3 files changed

// File: rtl/mesh_term_tx_pkg.sv
// Shared mesh packet definitions: header layout, field offsets and the
// terminal-position legality check used by generators and checkers alike.
package mesh_term_tx_pkg;

    localparam int unsigned NXT_JUMP_W = 8;
    localparam int unsigned COORD_W    = 4;
    localparam int unsigned MODE_W     = 1;
    localparam int unsigned HDR_W      = NXT_JUMP_W + 2 * COORD_W + MODE_W;

    // Header sits above the payload, next-jump byte at the packet MSB.
    typedef struct packed {
        logic [NXT_JUMP_W-1:0] nxt_jump;
        logic [COORD_W-1:0]    row;
        logic [COORD_W-1:0]    col;
        logic                  mode;
    } pkt_hdr_t;

    function automatic int unsigned payload_w(input int unsigned pakg_size);
        return pakg_size - HDR_W;
    endfunction

    function automatic int unsigned mode_lsb(input int unsigned pakg_size);
        return pakg_size - HDR_W;
    endfunction

    function automatic int unsigned col_lsb(input int unsigned pakg_size);
        return mode_lsb(pakg_size) + MODE_W;
    endfunction

    function automatic int unsigned row_lsb(input int unsigned pakg_size);
        return col_lsb(pakg_size) + COORD_W;
    endfunction

    function automatic int unsigned jump_lsb(input int unsigned pakg_size);
        return row_lsb(pakg_size) + COORD_W;
    endfunction

    // Terminals live on the mesh border ring, excluding the four corners.
    function automatic logic is_terminal(
        input logic [COORD_W-1:0] row,
        input logic [COORD_W-1:0] col,
        input int unsigned        rows,
        input int unsigned        cols
    );
        logic row_edge;
        logic col_edge;
        logic row_in;
        logic col_in;
        row_edge = (32'(row) == 32'd0) || (32'(row) == rows + 32'd1);
        col_edge = (32'(col) == 32'd0) || (32'(col) == cols + 32'd1);
        row_in   = (32'(row) >= 32'd1) && (32'(row) <= rows);
        col_in   = (32'(col) >= 32'd1) && (32'(col) <= cols);
        return (row_edge && col_in) || (col_edge && row_in);
    endfunction

endpackage

// File: rtl/mesh_term_fifo.sv
// First-word-fall-through packet buffer with modulo-depth pointers;
// the head reads as zero while the buffer is empty.
module mesh_term_fifo #(
    parameter int unsigned PAKG_SIZE  = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic                             pop,
    input  logic [PAKG_SIZE-1:0]             wdata,
    output logic [PAKG_SIZE-1:0]             rdata,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count,
    output logic                             empty
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [PAKG_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CNT_W'(FIFO_DEPTH)) || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and the empty gate hide stale words.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mesh_term_tx.sv
// Mesh terminal injector: formats producer packets, drops illegal
// destinations with an error pulse, and buffers them toward the router.
module mesh_term_tx
    import mesh_term_tx_pkg::*;
#(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLUMNS    = 4,
    parameter int unsigned PAKG_SIZE  = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [COORD_W-1:0]               in_row_i,
    input  logic [COORD_W-1:0]               in_col_i,
    input  logic                             in_mode_i,
    input  logic [PAKG_SIZE-HDR_W-1:0]       in_payload_i,
    output logic                             pndng_o,
    output logic [PAKG_SIZE-1:0]             data_out_o,
    input  logic                             popin_i,
    output logic                             err_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
    output logic [31:0]                      sent_cnt_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    pkt_hdr_t             hdr;
    logic [PAKG_SIZE-1:0] pkt;
    logic                 legal;
    logic                 hs;
    logic                 push;
    logic                 empty;

    always_comb begin
        hdr          = '0;
        hdr.nxt_jump = '0;
        hdr.row      = in_row_i;
        hdr.col      = in_col_i;
        hdr.mode     = in_mode_i;
        pkt          = {hdr, in_payload_i};
    end

    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign in_ready_o = rst_i && ((count_o < CNT_W'(FIFO_DEPTH)) || popin_i);
    assign legal      = is_terminal(in_row_i, in_col_i, ROWS, COLUMNS);
    assign hs         = in_valid_i && in_ready_o;
    assign push       = hs && legal;
    assign pndng_o    = !empty;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            err_o      <= 1'b0;
            sent_cnt_o <= '0;
        end else begin
            err_o <= hs && !legal;
            if (popin_i && pndng_o) sent_cnt_o <= sent_cnt_o + 32'd1;
        end
    end

    mesh_term_fifo #(
        .PAKG_SIZE  (PAKG_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_i),
        .push  (push),
        .pop   (popin_i),
        .wdata (pkt),
        .rdata (data_out_o),
        .count (count_o),
        .empty (empty)
    );

endmodule
